// File: rtl/matrix_mult_par_pkg.sv
// Shared types and helpers for the parallel matrix multiplier: controller states,
// accumulator sizing and the output range-check / clamp used at write-back.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Widest accumulator the helpers accept; callers extend their value to this width.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ONE_W = {{(MAX_W-1){1'b0}}, 1'b1};

  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  // True when the (already sign/zero-extended) value does not fit out_w bits.
  function automatic logic range_ovf(input logic [MAX_W-1:0] acc,
                                     input int               out_w,
                                     input logic             is_signed);
    logic [MAX_W-1:0] mask_s;
    logic [MAX_W-1:0] mask_u;
    logic             ovf;
    mask_s = ~((ONE_W << (out_w - 1)) - ONE_W);
    mask_u = ~((ONE_W << out_w) - ONE_W);
    if (is_signed) begin
      ovf = ((acc & mask_s) != '0) && ((acc & mask_s) != mask_s);
    end else begin
      ovf = ((acc & mask_u) != '0);
    end
    return ovf;
  endfunction

  // Returns the value to store; only the low out_w bits are meaningful.
  function automatic logic [MAX_W-1:0] clamp_value(input logic [MAX_W-1:0] acc,
                                                   input int               out_w,
                                                   input logic             is_signed,
                                                   input logic             sat);
    logic [MAX_W-1:0] mask_s;
    logic [MAX_W-1:0] lim;
    mask_s = ~((ONE_W << (out_w - 1)) - ONE_W);
    if (is_signed) begin
      lim = acc[MAX_W-1] ? mask_s : ~mask_s;
    end else begin
      lim = (ONE_W << out_w) - ONE_W;
    end
    if (sat && range_ovf(acc, out_w, is_signed)) begin
      return lim;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/matrix_mult_par_if.sv
// Operand/result bundle of the matrix multiplier; the requester uses master, the multiplier slave.
interface matrix_mult_par_if #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);

  logic [N*N*DATA_W-1:0] A;
  logic [N*N*DATA_W-1:0] B;
  logic                  Load;
  logic [N*N*OUT_W-1:0]  Out;
  logic [N*N-1:0]        Ovf;
  logic                  Done;

  modport master (
    output A, B, Load,
    input  Out, Ovf, Done
  );

  modport slave (
    input  A, B, Load,
    output Out, Ovf, Done
  );

endinterface

// File: rtl/matrix_mult_par_mac_cell.sv
// One multiply-accumulate cell: DATA_W x DATA_W product added into an ACC_W accumulator.
module mac_cell
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] a_ext_s;
  logic [2*DATA_W-1:0] b_ext_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    prod_ext_s;
  logic [ACC_W-1:0]    acc_r;

  // Operands are extended to the full product width so the low 2*DATA_W bits are exact in both modes.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_s = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext_s = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_ext_s = {{DATA_W{1'b0}}, a};
      b_ext_s = {{DATA_W{1'b0}}, b};
    end
    prod_s     = a_ext_s * b_ext_s;
    prod_ext_s = {{(ACC_W-2*DATA_W){(SIGNED != 0) & prod_s[2*DATA_W-1]}}, prod_s};
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + prod_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/matrix_mult_par.sv
// N x N matrix multiplier: latches A/B on Load, runs N accumulate steps in N*N parallel
// cells, then registers the wrapped or saturated result with per-element overflow flags.
module matrix_mult_par
  import matrix_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             Reset,
  matrix_mult_par_if.slave bus
);

  localparam int ACC_W = acc_width(DATA_W, N);
  localparam int K_W   = $clog2(N);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [K_W-1:0]        k_r;
  logic                  clr_s;
  logic                  en_s;
  logic [N*N*DATA_W-1:0] a_r;
  logic [N*N*DATA_W-1:0] b_r;
  logic [N*N*OUT_W-1:0]  out_nxt_s;
  logic [N*N-1:0]        ovf_nxt_s;
  logic [N*N*OUT_W-1:0]  out_r;
  logic [N*N-1:0]        ovf_r;

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle cell controls.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Load) begin
          state_nxt_s = ST_CALC;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        en_s = 1'b1;
        if (k_r == K_W'(N - 1)) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Step counter k.
  always_ff @(posedge clk) begin
    if (Reset) begin
      k_r <= '0;
    end else if (clr_s) begin
      k_r <= '0;
    end else if (en_s) begin
      k_r <= k_r + K_W'(1);
    end else begin
      k_r <= k_r;
    end
  end

  // Operand registers. Each CALC step shifts A left by one column and B up by one row, so
  // column 0 of A and row 0 of B always hold the k-th column/row; cells need no k mux.
  always_ff @(posedge clk) begin
    if (Reset) begin
      a_r <= '0;
      b_r <= '0;
    end else if (clr_s) begin
      a_r <= bus.A;
      b_r <= bus.B;
    end else if (en_s) begin
      a_r <= a_r >> DATA_W;
      b_r <= b_r >> (N * DATA_W);
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int E = gi * N + gj;

      logic [ACC_W-1:0] acc_s;
      logic [MAX_W-1:0] acc_ext_s;

      mac_cell #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_cell (
        .clk   (clk),
        .Reset (Reset),
        .clr   (clr_s),
        .en    (en_s),
        .a     (a_r[gi*N*DATA_W +: DATA_W]),
        .b     (b_r[gj*DATA_W +: DATA_W]),
        .acc   (acc_s)
      );

      // Extend to the helper width honouring signedness.
      always_comb begin
        if (SIGNED != 0) begin
          acc_ext_s = {{(MAX_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
        end else begin
          acc_ext_s = {{(MAX_W-ACC_W){1'b0}}, acc_s};
        end
      end

      assign out_nxt_s[E*OUT_W +: OUT_W] =
        OUT_W'(clamp_value(acc_ext_s, OUT_W, (SIGNED != 0), (SAT != 0)));
      assign ovf_nxt_s[E] = range_ovf(acc_ext_s, OUT_W, (SIGNED != 0));
    end
  end

  // Result registers, loaded only in WRITE and held otherwise.
  always_ff @(posedge clk) begin
    if (Reset) begin
      out_r <= '0;
      ovf_r <= '0;
    end else if (state_r == ST_WRITE) begin
      out_r <= out_nxt_s;
      ovf_r <= ovf_nxt_s;
    end else begin
      out_r <= out_r;
      ovf_r <= ovf_r;
    end
  end

  assign bus.Out  = out_r;
  assign bus.Ovf  = ovf_r;
  assign bus.Done = (state_r == ST_IDLE);

endmodule
